axi_multi_req_master: RTL and testbench
=======================================

// Module: axi_multi_req_master
// PURPOSE
//  Single-clock AXI4 master that arbitrates NUM_REQ cache-side requesters (default: L1C_inst, L1C_data)
//  onto one AXI read/write port with INCR bursts. Successor to the per-cache read/write master pair:
//  adds parametrised requester count, burst length per request, round-robin fairness and error reporting.
//  Sits between the L1 caches and the CDC FIFO wrappers in the CPU wrapper. One transaction in flight.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=1)
//  ADDR_W   32  address width
//  DATA_W   32  data width; STRB_W = DATA_W/8
//  ID_W     4   AXI ID width; ID issued = ID_BASE + requester index
//  ID_BASE  1   ID for requester 0
//  LEN_W    4   AXI LEN width (burst beats = len+1, max 16)
// PORTS
//  clk        in   1               clock
//  rst        in   1               async active-high reset
//  req_valid  in   NUM_REQ         requester i has a pending transaction
//  req_write  in   NUM_REQ         1=write, 0=read
//  req_addr   in   NUM_REQ*ADDR_W  start address (slice i)
//  req_len    in   NUM_REQ*LEN_W   AXI LEN (beats-1)
//  req_ready  out  NUM_REQ         one-cycle pulse: request i accepted
//  rd_valid   out  NUM_REQ         read beat for requester i on rd_data
//  rd_data    out  DATA_W          read data, shared by all requesters
//  rd_last    out  1               qualifies the final read beat
//  wr_data    in   NUM_REQ*DATA_W  write beat data (slice i)
//  wr_strb    in   NUM_REQ*STRB_W  write byte strobes (slice i)
//  wr_ready   out  NUM_REQ         write beat i consumed; requester advances to next beat
//  done       out  NUM_REQ         one-cycle pulse: transaction i complete (RLAST or B)
//  err        out  1               valid with done: RRESP/BRESP != OKAY on any beat
//  AR*/R*/AW*/W*/B*  standard AXI4 master signals (ARID..ARVALID in/ARREADY, RID..RVALID in/RREADY, etc.)
// BEHAVIOUR
//  - Reset: all *VALID, RREADY, BREADY, req_ready, rd_valid, wr_ready, done, err = 0; state IDLE; rr pointer = 0.
//  - FSM: IDLE -> AR -> R -> IDLE (read); IDLE -> AW -> W -> B -> IDLE (write).
//  - IDLE: grant = first i with req_valid[i], searching from rr pointer upward with wrap; latch addr, len,
//    write, grant; pulse req_ready[grant]; next state AR or AW. No request -> stay IDLE.
//  - AR/AW: *VALID=1 with latched addr/len, SIZE=log2(STRB_W), BURST=INCR, ID=ID_BASE+grant; held stable
//    until *READY; on handshake -> R / W. Accept->first VALID latency: 1 cycle.
//  - R: RREADY=1. Each RVALID beat: rd_valid[grant]=1, rd_data=RDATA (combinational pass-through),
//    beat counter++. On RLAST beat: rd_last=1, done[grant]=1, err=sticky|RRESP!=0, -> IDLE.
//    RLAST earlier than len+1 beats terminates normally; beats past len+1 are still forwarded (counter saturates).
//  - W: WVALID=1, WDATA/WSTRB = slice[grant]; wr_ready[grant]=WREADY; WLAST=1 when counter==len; on last
//    handshake -> B. BREADY=1 in B; on BVALID: done[grant]=1, err=(BRESP!=0), -> IDLE.
//  - rr pointer = grant+1 (mod NUM_REQ) on leaving R/B -> fairness: a continuously requesting port cannot
//    starve another. Request changes after req_ready are ignored until next IDLE.
//  - RID/BID mismatch against issued ID sets err (data still forwarded).
//  - Simultaneous req_valid on all ports: exactly one granted per IDLE cycle. IDLE->grant costs 1 cycle.
//  - Async reset mid-burst: return to IDLE immediately, all valids drop; no done pulse for aborted transaction.
// STRUCTURE
//  - axi_bridge_pkg: state enum (IDLE,AR,R,AW,W,B), AXI_RESP_OKAY, AXI_BURST_INCR, size function.
//  - Sub-module rr_arbiter #(N): req vector, pointer, advance strobe -> one-hot grant + index.
//  - Top: FSM, latch registers, beat counter, output muxes.
// TESTING
//  1 Read len=3 from req0 at 0x0000_0100, slave RDATA 0xA0..A3 -> ARID=1, ARLEN=3, 4 rd_valid[0], rd_last+done[0] on 4th, err=0.
//  2 req0 and req1 both valid for 4 transactions each -> grants alternate 0,1,0,1...; ID 1/2 seen on AR/AW.
//  3 Write len=1 from req1 addr 0x2000, WREADY low 2 cycles per beat -> WVALID/WDATA held, WLAST on beat 2, done[1] on BVALID.
//  4 BRESP=2'b10 on write, then RRESP=2'b10 on beat 1 of a 4-beat read -> err=1 with each done; beats still forwarded.
//  5 ARREADY held low 10 cycles -> ARVALID/ARADDR stable throughout; no req_ready for other port meanwhile.
//  6 rst asserted during beat 2 of read -> all outputs 0 same cycle; after release, new request granted normally.

Source files
------------

// File: rtl/axi_multi_req_master_pkg.sv
// Shared types and helpers for the multi-requester AXI4 master.
// Contents: FSM state encoding, AXI response/burst constants,
// a transfer-size helper and an index-width helper.
package axi_multi_req_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // AXI SIZE encoding: log2 of the number of bytes per beat
    function automatic logic [2:0] axi_size(input int strb_w);
        return 3'($clog2(strb_w));
    endfunction

    // Width of a requester index; never below one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_multi_req_master_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, rst      clock, async active-high reset (pointer returns to 0)
//   req           request vector
//   advance       strobe: the granted transaction has finished
//   advance_idx   index of that transaction; the pointer moves just past it
//   grant         one-hot grant (combinational)
//   grant_idx     binary index of the grant
//   grant_valid   at least one request present
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    input  logic [IDX_W-1:0] advance_idx,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W:0]   cand_s;

    // Pointer register: highest priority goes to the requester after the last served one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= (advance_idx == IDX_W'(N - 1)) ? '0 : advance_idx + IDX_W'(1);
        end
    end

    // Search upward from the pointer with wrap-around; first hit wins
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr_r} + (IDX_W + 1)'(k);
            if (cand_s >= (IDX_W + 1)'(N)) begin
                cand_s = cand_s - (IDX_W + 1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_valid && req[cand_s[IDX_W-1:0]]) begin
                grant_valid                 = 1'b1;
                grant_idx                   = cand_s[IDX_W-1:0];
                grant[cand_s[IDX_W-1:0]]    = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/axi_multi_req_master.sv
// AXI4 master shared by NUM_REQ cache-side requesters, one transaction in flight.
// A round-robin arbiter picks a requester in IDLE; its address/length are latched
// and an INCR burst is issued (AR->R for reads, AW->W->B for writes).
// Ports:
//   clk, rst                        clock, async active-high reset
//   req_valid/write/addr/len        per-requester request (packed slices)
//   req_ready                       one-cycle accept pulse to the granted requester
//   rd_valid/rd_data/rd_last        read beats routed to the granted requester
//   wr_data/wr_strb/wr_ready        write beats pulled from the granted requester
//   done/err                        completion pulse, err qualifies it
//   ar*/r*/aw*/w*/b*                AXI4 master channels
module axi_multi_req_master
    import axi_multi_req_master_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int ID_BASE = 1,
    parameter int LEN_W   = 4,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_last,
    input  logic [NUM_REQ*DATA_W-1:0]  wr_data,
    input  logic [NUM_REQ*STRB_W-1:0]  wr_strb,
    output logic [NUM_REQ-1:0]         wr_ready,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic [ID_W-1:0]            arid,
    output logic [ADDR_W-1:0]          araddr,
    output logic [LEN_W-1:0]           arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [ID_W-1:0]            rid,
    input  logic [DATA_W-1:0]          rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    output logic [ID_W-1:0]            awid,
    output logic [ADDR_W-1:0]          awaddr,
    output logic [LEN_W-1:0]           awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [DATA_W-1:0]          wdata,
    output logic [STRB_W-1:0]          wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [ID_W-1:0]            bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_e              state_r;
    logic [IDX_W-1:0]    grant_idx_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    beat_cnt_r;
    logic                err_sticky_r;
    logic                arvalid_r;
    logic                awvalid_r;
    logic                wvalid_r;
    logic                rready_r;
    logic                bready_r;
    logic [NUM_REQ-1:0]  req_ready_r;

    logic [ADDR_W-1:0]   addr_arr_s [NUM_REQ];
    logic [LEN_W-1:0]    len_arr_s  [NUM_REQ];
    logic [DATA_W-1:0]   data_arr_s [NUM_REQ];
    logic [STRB_W-1:0]   strb_arr_s [NUM_REQ];

    logic [NUM_REQ-1:0]  arb_grant_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic                arb_valid_s;
    logic [NUM_REQ-1:0]  sel_s;
    logic [ID_W-1:0]     id_s;
    logic                rd_fire_s;
    logic                rd_done_s;
    logic                b_done_s;
    logic                beat_err_s;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr_s[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign len_arr_s[gi]  = req_len[gi*LEN_W +: LEN_W];
        assign data_arr_s[gi] = wr_data[gi*DATA_W +: DATA_W];
        assign strb_arr_s[gi] = wr_strb[gi*STRB_W +: STRB_W];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .advance     (rd_done_s || b_done_s),
        .advance_idx (grant_idx_r),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    assign id_s       = ID_W'(ID_BASE) + ID_W'(grant_idx_r);
    assign rd_fire_s  = (state_r == ST_R) && rvalid;
    assign rd_done_s  = rd_fire_s && rlast;
    assign b_done_s   = (state_r == ST_B) && bvalid;
    // A wrong RID is reported but the beat is still delivered
    assign beat_err_s = (rresp != AXI_RESP_OKAY) || (rid != id_s);

    // One-hot decode of the latched grant for output routing
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_s[i] = (grant_idx_r == IDX_W'(i));
        end
    end

    // Transaction FSM: arbitration, address/data phases, response collection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_idx_r  <= '0;
            addr_r       <= '0;
            len_r        <= '0;
            beat_cnt_r   <= '0;
            err_sticky_r <= 1'b0;
            arvalid_r    <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            rready_r     <= 1'b0;
            bready_r     <= 1'b0;
            req_ready_r  <= '0;
        end else begin
            req_ready_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        grant_idx_r <= arb_idx_s;
                        addr_r      <= addr_arr_s[arb_idx_s];
                        len_r       <= len_arr_s[arb_idx_s];
                        req_ready_r <= arb_grant_s;
                        if (req_write[arb_idx_s]) begin
                            awvalid_r <= 1'b1;
                            state_r   <= ST_AW;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid_r    <= 1'b0;
                        rready_r     <= 1'b1;
                        beat_cnt_r   <= '0;
                        err_sticky_r <= 1'b0;
                        state_r      <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        // Counter saturates so over-long bursts are still forwarded
                        if (beat_cnt_r != {LEN_W{1'b1}}) begin
                            beat_cnt_r <= beat_cnt_r + LEN_W'(1);
                        end
                        err_sticky_r <= err_sticky_r || beat_err_s;
                        if (rlast) begin
                            rready_r <= 1'b0;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                ST_AW: begin
                    if (awready) begin
                        awvalid_r  <= 1'b0;
                        wvalid_r   <= 1'b1;
                        beat_cnt_r <= '0;
                        state_r    <= ST_W;
                    end
                end
                ST_W: begin
                    if (wready) begin
                        if (beat_cnt_r == len_r) begin
                            wvalid_r <= 1'b0;
                            bready_r <= 1'b1;
                            state_r  <= ST_B;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + LEN_W'(1);
                        end
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        bready_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    arvalid_r <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    rready_r  <= 1'b0;
                    bready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rd_valid  = rd_fire_s ? sel_s : '0;
    assign rd_data   = rdata;
    assign rd_last   = rd_done_s;
    assign wr_ready  = ((state_r == ST_W) && wready) ? sel_s : '0;
    assign done      = (rd_done_s || b_done_s) ? sel_s : '0;
    assign err       = (rd_done_s && (err_sticky_r || beat_err_s))
                    || (b_done_s && ((bresp != AXI_RESP_OKAY) || (bid != id_s)));

    assign arid    = id_s;
    assign araddr  = addr_r;
    assign arlen   = len_r;
    assign arsize  = axi_size(STRB_W);
    assign arburst = AXI_BURST_INCR;
    assign arvalid = arvalid_r;
    assign rready  = rready_r;

    assign awid    = id_s;
    assign awaddr  = addr_r;
    assign awlen   = len_r;
    assign awsize  = axi_size(STRB_W);
    assign awburst = AXI_BURST_INCR;
    assign awvalid = awvalid_r;

    assign wdata   = data_arr_s[grant_idx_r];
    assign wstrb   = strb_arr_s[grant_idx_r];
    assign wlast   = wvalid_r && (beat_cnt_r == len_r);
    assign wvalid  = wvalid_r;
    assign bready  = bready_r;

endmodule

// File: tb/tb_axi_multi_req_master.sv
// Self-checking bench: a directed vector table, arbitration/reset sequences and
// randomized transactions, all compared against expectations derived from the
// request parameters and a round-robin pointer model.
module tb_axi_multi_req_master;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int LW = 4;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_write, req_ready, rd_valid, wr_ready, done;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic [DW-1:0]    rd_data, rdata, wdata;
    logic             rd_last, err;
    logic [NR*DW-1:0] wr_data;
    logic [NR*SW-1:0] wr_strb;
    logic [IW-1:0]    arid, rid, awid, bid;
    logic [AW-1:0]    araddr, awaddr;
    logic [LW-1:0]    arlen, awlen;
    logic [2:0]       arsize, awsize;
    logic [1:0]       arburst, awburst, rresp, bresp;
    logic             arvalid, arready, rlast, rvalid, rready;
    logic             awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [SW-1:0]    wstrb;

    axi_multi_req_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_ready(wr_ready), .done(done), .err(err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;   // round-robin pointer of the reference model

    typedef struct {
        int          g;
        bit          wr;
        logic [31:0] addr;
        int          len;
        int          nbeats;
        int          astall;
        int          wstall;
        int          err_beat;
        logic [1:0]  bresp;
        bit          bad_id;
        logic [3:0]  exp_id;
        bit          exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wpat(input int g, input int b);
        return 32'hD000_0000 | (32'(g) << 8) | 32'(b);
    endfunction

    // Expected grant: first valid requester at or after the model pointer
    function automatic int model_grant(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[(model_ptr + k) % NR]) return (model_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic check_all_idle(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Drive one transaction as the AXI slave and check every observable step
    task automatic run_txn(input int g, input bit wr, input logic [31:0] addr, input int len,
                           input int nbeats, input int astall, input int wstall, input int err_beat,
                           input logic [1:0] br, input bit bad_id, input logic [3:0] exp_id,
                           input bit exp_err, input logic [31:0] rbase, input bit drop);
        logic [NR-1:0] oh;
        int seen;
        int lat;
        bit last;
        oh = '0;
        oh[g] = 1'b1;
        seen = 0;
        lat = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk); #1;
            if (req_ready != '0) begin
                seen = 1;
                lat = c;
            end
        end
        chk("accept_seen", seen, 1);
        if (seen == 0) return;
        chk("accept_latency", lat, 0);
        chk("req_ready", req_ready, oh);
        if (drop) req_valid[g] = 1'b0;
        if (!wr) begin
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, addr);
            chk("arlen", arlen, len);
            chk("arid", arid, exp_id);
            chk("arsize", arsize, 3'd2);
            chk("arburst", arburst, 2'b01);
            for (int s = 0; s < astall; s++) begin
                @(negedge clk); #1;
                chk("ar_hold", arvalid, 1);
                chk("ar_addr_hold", araddr, addr);
                chk("no_grant_busy", req_ready, 0);
            end
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0;
            for (int b = 0; b < nbeats; b++) begin
                last   = (b == nbeats - 1);
                rvalid = 1'b1;
                rdata  = rbase + 32'(b);
                rresp  = (b == err_beat) ? 2'b10 : 2'b00;
                rlast  = last;
                rid    = bad_id ? exp_id + 4'd1 : exp_id;
                #1;
                chk("rready", rready, 1);
                chk("rd_valid", rd_valid, oh);
                chk("rd_data", rd_data, rbase + 32'(b));
                chk("rd_last", rd_last, last);
                chk("rd_done", done, last ? oh : '0);
                chk("rd_err", err, last ? exp_err : 1'b0);
                @(negedge clk);
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            #1;
            chk("rd_after_valid", rd_valid, 0);
            chk("rd_after_done", done, 0);
            chk("rd_after_rready", rready, 0);
        end else begin
            chk("awvalid", awvalid, 1);
            chk("awaddr", awaddr, addr);
            chk("awlen", awlen, len);
            chk("awid", awid, exp_id);
            chk("awburst", awburst, 2'b01);
            for (int s = 0; s < astall; s++) begin
                @(negedge clk); #1;
                chk("aw_hold", awvalid, 1);
                chk("no_grant_busy", req_ready, 0);
            end
            awready = 1'b1;
            @(negedge clk);
            awready = 1'b0;
            for (int b = 0; b <= len; b++) begin
                wr_data[g*DW +: DW] = wpat(g, b);
                wr_strb[g*SW +: SW] = 4'hF - 4'(b);
                for (int s = 0; s < wstall; s++) begin
                    wready = 1'b0;
                    #1;
                    chk("w_hold_valid", wvalid, 1);
                    chk("w_hold_data", wdata, wpat(g, b));
                    chk("w_hold_last", wlast, b == len);
                    chk("w_hold_wr_ready", wr_ready, 0);
                    @(negedge clk);
                end
                wready = 1'b1;
                #1;
                chk("wvalid", wvalid, 1);
                chk("wdata", wdata, wpat(g, b));
                chk("wstrb", wstrb, 4'hF - 4'(b));
                chk("wlast", wlast, b == len);
                chk("wr_ready", wr_ready, oh);
                @(negedge clk);
                wready = 1'b0;
            end
            #1;
            chk("bready", bready, 1);
            chk("wvalid_after", wvalid, 0);
            chk("done_before_b", done, 0);
            bvalid = 1'b1;
            bresp  = br;
            bid    = bad_id ? exp_id + 4'd1 : exp_id;
            #1;
            chk("wr_done", done, oh);
            chk("wr_err", err, exp_err);
            @(negedge clk);
            bvalid = 1'b0;
            #1;
            chk("wr_after_done", done, 0);
        end
        model_ptr = (g + 1) % NR;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic [NR-1:0] mask;
        int   gexp;
        int   ok;
        logic [31:0] ra [NR];
        int   rl [NR];
        bit   rw [NR];

        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        wr_data = {32'hBAD1_BAD1, 32'hBAD0_BAD0};
        wr_strb = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;

        // Directed table: g, wr, addr, len, nbeats, astall, wstall, err_beat, bresp, bad_id, id, err
        vecs[0] = '{0, 1'b0, 32'h0000_0100, 3, 4, 0,  0, -1, 2'b00, 1'b0, 4'd1, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0000_2000, 1, 0, 0,  2, -1, 2'b00, 1'b0, 4'd2, 1'b0};
        vecs[2] = '{0, 1'b1, 32'h0000_0300, 0, 0, 1,  0, -1, 2'b10, 1'b0, 4'd1, 1'b1};
        vecs[3] = '{0, 1'b0, 32'h0000_0400, 3, 4, 0,  0,  1, 2'b00, 1'b0, 4'd1, 1'b1};
        vecs[4] = '{1, 1'b0, 32'h0000_0500, 0, 1, 10, 0, -1, 2'b00, 1'b0, 4'd2, 1'b0};
        vecs[5] = '{0, 1'b0, 32'h0000_0600, 1, 2, 0,  0, -1, 2'b00, 1'b1, 4'd1, 1'b1};
        vecs[6] = '{1, 1'b0, 32'h0000_0700, 3, 2, 0,  0, -1, 2'b00, 1'b0, 4'd2, 1'b0};
        vecs[7] = '{0, 1'b0, 32'h0000_0800, 0, 3, 0,  0, -1, 2'b00, 1'b0, 4'd1, 1'b0};
        vecs[8] = '{1, 1'b1, 32'h0000_0900, 3, 0, 0,  1, -1, 2'b00, 1'b1, 4'd2, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        check_all_idle("reset");
        rst = 1'b0;
        @(negedge clk); #1;
        check_all_idle("post_reset");

        // Directed vectors, one requester at a time
        foreach (vecs[i]) begin
            v = vecs[i];
            req_valid = '0;
            req_valid[v.g] = 1'b1;
            req_write[v.g] = v.wr;
            req_addr[v.g*AW +: AW] = v.addr;
            req_len[v.g*LW +: LW] = 4'(v.len);
            gexp = model_grant(req_valid);
            run_txn(gexp, v.wr, v.addr, v.len, v.nbeats, v.astall, v.wstall, v.err_beat,
                    v.bresp, v.bad_id, v.exp_id, v.exp_err, 32'h0000_00A0, 1'b1);
        end

        // Both requesters continuously valid: grants must alternate
        req_valid = 2'b11;
        req_write = 2'b10;
        req_addr  = {32'h0000_1100, 32'h0000_1000};
        req_len   = '0;
        for (int t = 0; t < 8; t++) begin
            gexp = model_grant(req_valid);
            run_txn(gexp, gexp == 1, (gexp == 1) ? 32'h0000_1100 : 32'h0000_1000, 0, 1, 2, 0, -1,
                    2'b00, 1'b0, 4'(1 + gexp), 1'b0, 32'h0000_5000 + 32'(t), 1'b0);
        end
        req_valid = '0;

        // Randomized transactions against the model
        for (int it = 0; it < 24; it++) begin
            int nb, eb, as, ws;
            bit bi, ee;
            logic [1:0] brr;
            mask = 2'($urandom_range(1, 3));
            for (int r = 0; r < NR; r++) begin
                rw[r] = 1'($urandom_range(0, 1));
                ra[r] = $urandom & 32'hFFFF_FFFC;
                rl[r] = $urandom_range(0, 3);
                req_write[r] = rw[r];
                req_addr[r*AW +: AW] = ra[r];
                req_len[r*LW +: LW] = 4'(rl[r]);
            end
            req_valid = mask;
            gexp = model_grant(mask);
            nb  = rl[gexp] + 1;
            eb  = $urandom_range(0, 7);
            as  = $urandom_range(0, 2);
            ws  = $urandom_range(0, 2);
            bi  = ($urandom_range(0, 7) == 0);
            brr = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            ee  = rw[gexp] ? (bi || (brr != 2'b00)) : (bi || (eb < nb));
            run_txn(gexp, rw[gexp], ra[gexp], rl[gexp], nb, as, ws, eb, brr, bi,
                    4'(1 + gexp), ee, $urandom, 1'b1);
        end
        req_valid = '0;
        @(negedge clk);

        // Reset in the middle of a read burst, then normal operation resumes
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0 +: AW] = 32'h0000_0A00;
        req_len[0 +: LW] = 4'd3;
        ok = 0;
        for (int c = 0; c < 10 && ok == 0; c++) begin
            @(negedge clk); #1;
            if (req_ready != '0) ok = 1;
        end
        chk("rst_seq_accept", ok, 1);
        req_valid[0] = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rvalid = 1'b1; rdata = 32'h0000_00C0 + 32'(b); rresp = 2'b00; rlast = 1'b0; rid = 4'd1;
            @(negedge clk);
        end
        rvalid = 1'b1;
        rdata  = 32'h0000_00C2;
        rst    = 1'b1;
        #1;
        check_all_idle("mid_burst_reset");
        @(negedge clk);
        rvalid = 1'b0;
        rst    = 1'b0;
        model_ptr = 0;
        #1;
        check_all_idle("after_reset_release");
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[AW +: AW] = 32'h0000_0C00;
        req_len[LW +: LW] = 4'd1;
        gexp = model_grant(req_valid);
        run_txn(gexp, 1'b0, 32'h0000_0C00, 1, 2, 0, 0, -1, 2'b00, 1'b0, 4'd2, 1'b0,
                32'h0000_0E00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
